alu_pipe: RTL and testbench

//  Parametrised, registered ALU result stage: decodes an 8-way op select over WIDTH-bit

---
 rtl/alu_pipe_pkg.sv | 22 ++
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe_core.sv | 56 +++++
 rtl/alu_pipe.sv | 82 ++++++++
 tb/tb_alu_pipe.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe result stage: op-code encodings and the flag bundle.
// The optional saturating ADD/SUB behaviour is selected by the ALU_SAT_EN macro (see alu_core).
package alu_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
  localparam logic [OP_W-1:0] OP_OR   = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b111;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/op request channel and result/flag response channel of the alu_pipe stage.
// master drives operands and consumes results; slave is the ALU stage itself.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);

  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                a;
  logic [WIDTH-1:0]                b;
  logic [alu_pipe_pkg::OP_W-1:0]   op;
  logic                            use_acc;
  logic                            acc_clr;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                result;
  logic                            carry;
  logic                            zero;
  logic                            negative;

  modport master (
    output in_valid, a, b, op, use_acc, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative
  );

  modport slave (
    input  in_valid, a, b, op, use_acc, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, zero, negative
  );

endinterface

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational 8-way op decode producing result and raw carry/borrow.
// With ALU_SAT_EN defined ADD clamps to all-ones on carry and SUB clamps to zero on borrow.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] shamt;

  // Extra MSB of the difference is the unsigned borrow (A < B).
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_PASS: res_o = a_i;
      OP_ADD: begin
        carry_o = sum[WIDTH];
`ifdef ALU_SAT_EN
        res_o   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        res_o   = sum[WIDTH-1:0];
`endif
      end
      OP_AND:  res_o = a_i & b_i;
      OP_NOT:  res_o = ~a_i;
      OP_SUB: begin
        carry_o = diff[WIDTH];
`ifdef ALU_SAT_EN
        res_o   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        res_o   = diff[WIDTH-1:0];
`endif
      end
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SHL:  res_o = a_i << shamt;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU result stage with valid/ready handshake and a chaining accumulator.
// Optional saturating arithmetic is enabled by defining ALU_SAT_EN (handled in alu_core).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // acc_clr in the same cycle as a chained op makes that op see a zero operand.
  assign a_eff = bus.use_acc ? (bus.acc_clr ? '0 : acc_q) : bus.a;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (a_eff),
    .b_i     (bus.b),
    .op_i    (bus.op),
    .res_o   (core_res),
    .carry_o (core_carry)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      result_d         = core_res;
      flags_d.carry    = core_carry;
      flags_d.zero     = (core_res == '0);
      flags_d.negative = core_res[WIDTH-1];
      acc_d            = core_res;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (bus.acc_clr) begin
        acc_d = '0;
      end
    end
  end

  // Result stage boundary: everything below is held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = flags_q.carry;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed vector table, handshake corner sequences,
// and a randomized run against an arithmetic reference model. Honours ALU_SAT_EN.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.use_acc  = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.op       = 'x;
    bus.a        = 'x;
    bus.b        = 'x;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.use_acc  = ua;
    bus.acc_clr  = 1'b0;
  endtask

  // Reference arithmetic straight from the op table.
  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int res, output int c);
    int s;
    c = 0;
    case (op)
      0: res = a;
      1: begin
        s = a + b; c = (s > MASK) ? 1 : 0; res = s & MASK;
`ifdef ALU_SAT_EN
        if (c != 0) res = MASK;
`endif
      end
      2: res = a & b;
      3: res = (~a) & MASK;
      4: begin
        c = (a < b) ? 1 : 0; res = (a - b + MASK + 1) & MASK;
`ifdef ALU_SAT_EN
        if (c != 0) res = 0;
`endif
      end
      5: res = a | b;
      6: res = a ^ b;
      default: res = (a << (b % 8)) & MASK;
    endcase
  endfunction

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[12];

  // Random-run model state
  int m_ov, m_res, m_c, m_acc;

  initial begin
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;

    vecs[0]  = '{"add_f0_20",  3'd1, 8'hF0, 8'h20,
`ifdef ALU_SAT_EN
                 8'hFF, 1'b1, 1'b0, 1'b1};
`else
                 8'h10, 1'b1, 1'b0, 1'b0};
`endif
    vecs[1]  = '{"sub_03_05",  3'd4, 8'h03, 8'h05,
`ifdef ALU_SAT_EN
                 8'h00, 1'b1, 1'b1, 1'b0};
`else
                 8'hFE, 1'b1, 1'b0, 1'b1};
`endif
    vecs[2]  = '{"pass_5a",    3'd0, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"and",        3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"not_0f",     3'd3, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"or",         3'd5, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"xor_zero",   3'd6, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"shl_1",      3'd7, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"shl_7_trunc",3'd7, 8'h01, 8'h0F, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{"add_7f_01",  3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"sub_equal",  3'd4, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{"add_ff_01",  3'd1, 8'hFF, 8'h01,
`ifdef ALU_SAT_EN
                 8'hFF, 1'b1, 1'b0, 1'b1};
`else
                 8'h00, 1'b1, 1'b1, 1'b0};
`endif

    // Reset state
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result),    32'h00);
    chk("rst_flags",     32'({bus.carry, bus.zero, bus.negative}), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    issue(3'd0, 8'h77, 8'h00, 1'b1);
    cyc();
    idle();
    chk("rst_acc_zero",  32'(bus.result),    32'h00);
    chk("rst_acc_zflag", 32'(bus.zero),      32'd1);
    cyc();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      cyc();
      idle();
      chk({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({vecs[i].name, "_res"},   32'(bus.result),    32'(vecs[i].res));
      chk({vecs[i].name, "_flags"}, 32'({bus.carry, bus.zero, bus.negative}),
          32'({vecs[i].c, vecs[i].z, vecs[i].n}));
      cyc();
    end
    chk("drained_valid", 32'(bus.out_valid), 32'd0);

    // Stall holds the result and back-pressures the next op
    bus.out_ready = 1'b0;
    issue(3'd3, 8'hFF, 8'h00, 1'b0);
    cyc();
    issue(3'd0, 8'h33, 8'h00, 1'b0);
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_res",      32'(bus.result),   32'h00);
    chk("stall_zero",     32'(bus.zero),     32'd1);
    cyc();
    cyc();
    chk("stall_held_res",   32'(bus.result),    32'h00);
    chk("stall_held_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    idle();
    chk("release_res",   32'(bus.result),    32'h33);
    chk("release_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    chk("release_once_valid", 32'(bus.out_valid), 32'd0);
    chk("release_once_res",   32'(bus.result),    32'h33);

    // Accumulator clear then chained adds with no bubble
    bus.acc_clr = 1'b1;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      issue(3'd1, 8'h00, 8'h05, 1'b1);
      cyc();
      chk($sformatf("chain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("chain%0d_res", k),   32'(bus.result),    32'(5 * k));
    end
    idle();
    cyc();

    // Reset while stalled with a pending result
    bus.out_ready = 1'b0;
    issue(3'd0, 8'h44, 8'h00, 1'b0);
    cyc();
    idle();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_res",   32'(bus.result),    32'h00);
    bus.out_ready = 1'b1;
    issue(3'd0, 8'h00, 8'h00, 1'b1);
    cyc();
    idle();
    chk("midrst_acc", 32'(bus.result), 32'h00);
    cyc();

    // Randomized run against the model
    m_ov = 0; m_res = 0; m_c = 0; m_acc = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      int aeff, r, c, rdy, ov_n, res_n, c_n, acc_n;
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.use_acc   = $urandom_range(0, 1);
      bus.acc_clr   = ($urandom_range(0, 9) == 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      #1;
      rdy = (m_ov == 0 || bus.out_ready) ? 1 : 0;
      chk("rand_in_ready", 32'(bus.in_ready), 32'(rdy));
      ov_n = m_ov; res_n = m_res; c_n = m_c; acc_n = m_acc;
      if (rst) begin
        ov_n = 0; res_n = 0; c_n = 0; acc_n = 0;
      end else if (bus.in_valid && rdy != 0) begin
        aeff = bus.use_acc ? (bus.acc_clr ? 0 : m_acc) : int'(bus.a);
        alu_ref(int'(bus.op), aeff, int'(bus.b), r, c);
        ov_n = 1; res_n = r; c_n = c; acc_n = r;
      end else begin
        if (m_ov != 0 && bus.out_ready) ov_n = 0;
        if (bus.acc_clr) acc_n = 0;
      end
      m_ov = ov_n; m_res = res_n; m_c = c_n; m_acc = acc_n;
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rand_rst_state", 32'({bus.out_valid, bus.result, bus.carry, bus.zero, bus.negative}), 32'd0);
      end else begin
        chk("rand_state", 32'({bus.out_valid, bus.result, bus.carry, bus.zero, bus.negative}),
            32'({m_ov[0], m_res[7:0], m_c[0], (m_res == 0 && m_ov_seen_load()), m_res[7]}));
      end
    end
    rst = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // After reset zero flag is 0 even though result is 0; it only reflects a loaded result.
  bit loaded = 1'b0;
  function automatic bit m_ov_seen_load();
    return loaded;
  endfunction
  always @(posedge clk) begin
    if (rst) loaded <= 1'b0;
    else if (bus.in_valid && bus.in_ready) loaded <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
